// File: rtl/dma_axi_burst_w_if.sv
`default_nettype none
// ============================================================================
// Module   : dma_axi_burst_w_if
// Brief    : AXI4 write-channel bundle (AW, W, B) between the burst-write DMA
//            engine (master) and the system interconnect (slave).
// Revision : 1.0 - initial release
// ============================================================================
interface dma_axi_burst_w_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8
);
   logic [3:0]          awid;
   logic                awlock;
   logic [3:0]          awcache;
   logic [2:0]          awprot;
   logic [3:0]          awqos;
   logic [ADDR_W-1:0]   awaddr;
   logic [LEN_W-1:0]    awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awvalid;
   logic                awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   modport master (
      output awid, awlock, awcache, awprot, awqos,
      output awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      input  awid, awlock, awcache, awprot, awqos,
      input  awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );
endinterface
`default_nettype wire

// File: rtl/dma_axi_burst_w.sv
`default_nettype none
// ============================================================================
// Module   : dma_axi_burst_w
// Brief    : AXI4 write-master DMA engine. Moves one programmed transfer from a
//            valid/ready stream onto AXI, split into INCR bursts of at most
//            max_len+1 beats. Define DMA_AXI_BURST_W_4K_SPLIT_EN to also stop
//            every burst at a 4 KB boundary.
// Revision : 1.0 - initial release
// ============================================================================
module dma_axi_burst_w #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 8,
   parameter int XFER_W = 16
) (
   input  wire                  clk,
   input  wire                  rst_n,
   input  wire                  start_i,
   input  wire [ADDR_W-1:0]     start_addr_i,
   input  wire [XFER_W-1:0]     xfer_beats_i,
   input  wire [LEN_W-1:0]      max_len_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 error_o,
   input  wire                  s_valid_i,
   output logic                 s_ready_o,
   input  wire [DATA_W-1:0]     s_data_i,
   input  wire [DATA_W/8-1:0]   s_strb_i,
   dma_axi_burst_w_if.master    m_axi
);

   localparam int STRB_W = DATA_W / 8;
   localparam int SIZE   = $clog2(STRB_W);
   // Arithmetic width wide enough for rem, max_len+1 and the 13-bit 4 KB term
   localparam int CW0    = (XFER_W > LEN_W + 1) ? XFER_W : LEN_W + 1;
   localparam int CW     = (CW0 > 13) ? CW0 : 13;
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(STRB_W - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [XFER_W-1:0] rem_q;
   logic [LEN_W-1:0]  max_len_q;
   logic [LEN_W-1:0]  awlen_q;
   logic [LEN_W-1:0]  beat_q;
   logic              done_q;
   logic              error_q;

   logic              w_start_ok, w_aw_hs, w_w_hs, w_b_hs, w_last;
   logic [CW-1:0]     w_blen_cur, w_cap, w_blen_a, w_blen;
   logic [ADDR_W-1:0] w_addr_inc, w_calc_addr;
   logic [XFER_W-1:0] w_rem_dec, w_calc_rem;
   logic [LEN_W-1:0]  w_calc_max, w_awlen_nxt;
`ifdef DMA_AXI_BURST_W_4K_SPLIT_EN
   logic [12:0]       w_bnd;
`endif

   assign w_start_ok = (state_q == IDLE) && start_i;
   assign w_aw_hs    = (state_q == ADDR) && m_axi.awready;
   assign w_w_hs     = (state_q == DATA) && s_valid_i && m_axi.wready;
   assign w_b_hs     = (state_q == RESP) && m_axi.bvalid;
   assign w_last     = (beat_q == awlen_q);

   // Advance past the burst just completed
   assign w_blen_cur = CW'(awlen_q) + CW'(1);
   assign w_addr_inc = addr_q + (ADDR_W'(w_blen_cur) << SIZE);
   assign w_rem_dec  = rem_q - XFER_W'(w_blen_cur);

   // The next burst is sized either from the fresh request (IDLE) or from the
   // advanced position after a B response, so awlen is registered on ADDR entry
   assign w_calc_addr = (state_q == IDLE) ? (start_addr_i & ALIGN_MASK) : w_addr_inc;
   assign w_calc_rem  = (state_q == IDLE) ? xfer_beats_i : w_rem_dec;
   assign w_calc_max  = (state_q == IDLE) ? max_len_i : max_len_q;

   assign w_cap    = CW'(w_calc_max) + CW'(1);
   assign w_blen_a = (CW'(w_calc_rem) < w_cap) ? CW'(w_calc_rem) : w_cap;
`ifdef DMA_AXI_BURST_W_4K_SPLIT_EN
   assign w_bnd    = (13'd4096 - {1'b0, w_calc_addr[11:0]}) >> SIZE;
   assign w_blen   = (CW'(w_bnd) < w_blen_a) ? CW'(w_bnd) : w_blen_a;
`else
   assign w_blen   = w_blen_a;
`endif
   assign w_awlen_nxt = LEN_W'(w_blen - CW'(1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state: zero-beat requests complete without leaving IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (start_i && (xfer_beats_i != '0)) state_d = ADDR;
         ADDR: if (m_axi.awready) state_d = DATA;
         DATA: if (w_w_hs && w_last) state_d = RESP;
         RESP: if (m_axi.bvalid) state_d = (w_rem_dec == '0) ? IDLE : ADDR;
         default: state_d = IDLE;
      endcase
   end

   // Transfer bookkeeping: position, remaining beats, burst length, beat count, status
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= '0;
         rem_q     <= '0;
         max_len_q <= '0;
         awlen_q   <= '0;
         beat_q    <= '0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (w_start_ok) begin
            addr_q    <= w_calc_addr;
            rem_q     <= w_calc_rem;
            max_len_q <= max_len_i;
            error_q   <= 1'b0;
            if (xfer_beats_i != '0) awlen_q <= w_awlen_nxt;
            else                    done_q  <= 1'b1;
         end
         if (w_aw_hs) beat_q <= '0;
         if (w_w_hs)  beat_q <= beat_q + LEN_W'(1);
         if (w_b_hs) begin
            addr_q <= w_calc_addr;
            rem_q  <= w_calc_rem;
            if (m_axi.bresp != 2'b00) error_q <= 1'b1;
            if (w_rem_dec != '0) awlen_q <= w_awlen_nxt;
            else                 done_q  <= 1'b1;
         end
      end
   end

   // Outputs: handshakes decoded from state, W channel is a gated stream pass-through
   always_comb begin
      m_axi.awid    = 4'd0;
      m_axi.awlock  = 1'b0;
      m_axi.awcache = 4'b0010;
      m_axi.awprot  = 3'b010;
      m_axi.awqos   = 4'd0;
      m_axi.awsize  = 3'(SIZE);
      m_axi.awburst = 2'b01;
      m_axi.awaddr  = addr_q;
      m_axi.awlen   = awlen_q;
      m_axi.awvalid = (state_q == ADDR);
      m_axi.wvalid  = (state_q == DATA) && s_valid_i;
      m_axi.wlast   = (state_q == DATA) && w_last;
      m_axi.wdata   = (state_q == DATA) ? s_data_i : '0;
      m_axi.wstrb   = (state_q == DATA) ? s_strb_i : '0;
      m_axi.bready  = (state_q == RESP);
      s_ready_o     = (state_q == DATA) && m_axi.wready;
      busy_o        = (state_q != IDLE);
      done_o        = done_q;
      error_o       = error_q;
   end

endmodule
`default_nettype wire
